// File: rtl/vx_dma_splitter.sv
// vx_dma_splitter: takes one DMA transfer, cuts it into beat-sized copy
// commands, counts beat completions and returns the transfer tag.
module vx_dma_splitter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int TAG_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 4,
  localparam int BB = DATA_WIDTH / 8,
  localparam int BW = $clog2(BB) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_src_addr,
  input  logic [ADDR_WIDTH-1:0] req_dst_addr,
  input  logic [15:0]           req_size,
  input  logic                  req_direction,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  input  logic                  rsp_ready,
  output logic                  beat_valid,
  output logic [ADDR_WIDTH-1:0] beat_src_addr,
  output logic [ADDR_WIDTH-1:0] beat_dst_addr,
  output logic [BW-1:0]         beat_bytes,
  output logic                  beat_direction,
  output logic                  beat_last,
  input  logic                  beat_ready,
  input  logic                  cpl_valid,
  output logic                  busy,
  output logic                  err_spurious
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [15:0]           rem_q, rem_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  dir_q, dir_d;
  logic [OW-1:0]         out_q, out_d;
  logic                  err_q, err_d;

  logic is_issue;
  logic rem_small;
  logic beat_fire;
  logic cpl_ok;

  assign is_issue  = (state_q == ISSUE);
  assign rem_small = (rem_q <= 16'(BB));
  assign beat_fire = beat_valid & beat_ready;
  assign cpl_ok    = cpl_valid & (out_q != '0);

  assign req_ready      = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign rsp_valid      = (state_q == RESP);
  assign rsp_tag        = tag_q;
  assign beat_valid     = is_issue & (out_q < OW'(MAX_OUTSTANDING));
  assign beat_src_addr  = src_q;
  assign beat_dst_addr  = dst_q;
  assign beat_bytes     = rem_small ? BW'(rem_q) : BW'(BB);
  assign beat_last      = is_issue & rem_small;
  assign beat_direction = dir_q;
  assign err_spurious   = err_q;

  // A completion with nothing outstanding is flagged, never counted.
  always_comb begin
    out_d = out_q;
    if (beat_fire && !cpl_ok) begin
      out_d = out_q + OW'(1);
    end else if (!beat_fire && cpl_ok) begin
      out_d = out_q - OW'(1);
    end
    err_d = err_q | (cpl_valid & (out_q == '0));
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    tag_d   = tag_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          src_d   = req_src_addr;
          dst_d   = req_dst_addr;
          rem_d   = req_size;
          tag_d   = req_tag;
          dir_d   = req_direction;
          state_d = (req_size != '0) ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        if (beat_fire) begin
          src_d = src_q + ADDR_WIDTH'(BB);
          dst_d = dst_q + ADDR_WIDTH'(BB);
          rem_d = rem_q - 16'(beat_bytes);
          if (beat_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_d == '0) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      tag_q   <= '0;
      dir_q   <= 1'b0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      tag_q   <= tag_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

endmodule
